// File: rtl/pulse_stretch_pkg.sv
// Shared types and constants for the LED pulse stretcher.
// Simulation-sized pulse lengths keep benches short.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } ps_state_t;

    localparam int PS_ON_SIM  = 4;
    localparam int PS_OFF_SIM = 3;

endpackage

// File: rtl/stretch_timer.sv
// Down-counter shared by the ON and GAP phases.
// Loads on request, otherwise counts down and parks at zero.
module stretch_timer #(
    parameter int N = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    output logic         zero_o,
    output logic [N-1:0] count_o
);

    logic [N-1:0] count_q, count_d;

    // Next count: load wins, else decrement until zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - N'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Turns single-cycle ticks into fixed-length LED pulses with a
// mandatory low gap; extra ticks queue in a saturating counter.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int ON_CYCLES  = 2_000_000,
    parameter int OFF_CYCLES = 2_000_000,
    parameter int N          = 21,
    parameter int PEND_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              clr_ovf,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    localparam logic [N-1:0]      ON_LOAD  = N'(ON_CYCLES - 1);
    localparam logic [N-1:0]      OFF_LOAD = N'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    ps_state_t         state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              tmr_load;
    logic [N-1:0]      tmr_val;
    logic              tmr_zero;
    logic [N-1:0]      tmr_cnt_unused;
    logic              pend_inc;
    logic              pend_dec;

    stretch_timer #(
        .N(N)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero),
        .count_o    (tmr_cnt_unused)
    );

    // Phase sequencing; a queued event starts before a new tick.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = ON_LOAD;
        pend_dec = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    state_d  = ON;
                    tmr_load = 1'b1;
                    pend_dec = 1'b1;
                end else if (tick) begin
                    state_d  = ON;
                    tmr_load = 1'b1;
                end
            end
            ON: begin
                if (tmr_zero) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    if (pend_q != '0) begin
                        state_d  = ON;
                        tmr_load = 1'b1;
                        pend_dec = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
    end

    // Pending queue: a tick is queued unless it starts a pulse
    // directly from an empty IDLE; +1 and -1 on one edge cancel.
    always_comb begin
        pend_inc = tick && !((state_q == IDLE) && (pend_q == '0));
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (pend_inc && !pend_dec) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (pend_dec && !pend_inc) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign led     = led_q;
    assign busy    = busy_q;
    assign pending = pend_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed-vector bench for pulse_stretch (ON=4, OFF=3, PEND_W=2).
// Each vector drives tick/clr_ovf for one edge and checks all outputs.
module tb_pulse_stretch;
    import pulse_stretch_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       clr_ovf;
    logic       led;
    logic       busy;
    logic [1:0] pending;
    logic       ovf;

    int vec_cnt;
    int err_cnt;
    int step_no;

    pulse_stretch #(
        .ON_CYCLES  (PS_ON_SIM),
        .OFF_CYCLES (PS_OFF_SIM),
        .N          (3),
        .PEND_W     (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .clr_ovf (clr_ovf),
        .led     (led),
        .busy    (busy),
        .pending (pending),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s step %0d: got %0d expected %0d",
                     tag, step_no, got, exp);
        end
    endtask

    task automatic check_all(input logic el, input logic eb,
                             input logic [1:0] ep, input logic eo);
        check("led", 32'(led), 32'(el));
        check("busy", 32'(busy), 32'(eb));
        check("pending", 32'(pending), 32'(ep));
        check("ovf", 32'(ovf), 32'(eo));
    endtask

    task automatic vec(input logic t, input logic c, input logic el,
                       input logic eb, input logic [1:0] ep,
                       input logic eo);
        @(negedge clk);
        tick    = t;
        clr_ovf = c;
        @(posedge clk);
        #1;
        step_no++;
        check_all(el, eb, ep, eo);
    endtask

    task automatic vrep(input int n, input logic t, input logic c,
                        input logic el, input logic eb,
                        input logic [1:0] ep, input logic eo);
        for (int i = 0; i < n; i++) begin
            vec(t, c, el, eb, ep, eo);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        step_no = 0;
        rst_n   = 1'b0;
        tick    = 1'b0;
        clr_ovf = 1'b0;
        #1;
        check_all(1'b0, 1'b0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single tick: 4 high, 3 low-busy, then idle
        vrep(2, 0, 0, 0, 0, 0, 0);
        vec(1, 0, 1, 1, 0, 0);
        vrep(3, 0, 0, 1, 1, 0, 0);
        vrep(3, 0, 0, 0, 1, 0, 0);
        vrep(2, 0, 0, 0, 0, 0, 0);

        // three back-to-back ticks
        vec(1, 0, 1, 1, 0, 0);
        vec(1, 0, 1, 1, 1, 0);
        vec(1, 0, 1, 1, 2, 0);
        vec(0, 0, 1, 1, 2, 0);
        vrep(3, 0, 0, 0, 1, 2, 0);
        vrep(4, 0, 0, 1, 1, 1, 0);
        vrep(3, 0, 0, 0, 1, 1, 0);
        vrep(4, 0, 0, 1, 1, 0, 0);
        vrep(3, 0, 0, 0, 1, 0, 0);
        vec(0, 0, 0, 0, 0, 0);

        // five ticks: saturation, overflow, four pulses, clear
        vec(1, 0, 1, 1, 0, 0);
        vec(1, 0, 1, 1, 1, 0);
        vec(1, 0, 1, 1, 2, 0);
        vec(1, 0, 1, 1, 3, 0);
        vec(1, 0, 0, 1, 3, 1);
        vrep(2, 0, 0, 0, 1, 3, 1);
        vrep(4, 0, 0, 1, 1, 2, 1);
        vrep(3, 0, 0, 0, 1, 2, 1);
        vrep(4, 0, 0, 1, 1, 1, 1);
        vrep(3, 0, 0, 0, 1, 1, 1);
        vrep(4, 0, 0, 1, 1, 0, 1);
        vrep(3, 0, 0, 0, 1, 0, 1);
        vec(0, 0, 0, 0, 0, 1);
        vec(0, 1, 0, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 0);

        // tick on final GAP edge with pending=1: no extra gap
        vec(1, 0, 1, 1, 0, 0);
        vec(1, 0, 1, 1, 1, 0);
        vrep(2, 0, 0, 1, 1, 1, 0);
        vrep(3, 0, 0, 0, 1, 1, 0);
        vec(1, 0, 1, 1, 1, 0);
        vrep(3, 0, 0, 1, 1, 1, 0);
        vrep(3, 0, 0, 0, 1, 1, 0);
        vrep(4, 0, 0, 1, 1, 0, 0);
        vrep(3, 0, 0, 0, 1, 0, 0);
        vec(0, 0, 0, 0, 0, 0);

        // tick on final GAP edge with pending=0: one idle cycle
        vec(1, 0, 1, 1, 0, 0);
        vrep(3, 0, 0, 1, 1, 0, 0);
        vrep(3, 0, 0, 0, 1, 0, 0);
        vec(1, 0, 0, 0, 1, 0);
        vrep(4, 0, 0, 1, 1, 0, 0);
        vrep(3, 0, 0, 0, 1, 0, 0);
        vec(0, 0, 0, 0, 0, 0);

        // clr_ovf with saturating tick on same edge: set wins
        vec(1, 0, 1, 1, 0, 0);
        vec(1, 0, 1, 1, 1, 0);
        vec(1, 0, 1, 1, 2, 0);
        vec(1, 0, 1, 1, 3, 0);
        vec(1, 1, 0, 1, 3, 1);
        vrep(2, 0, 0, 0, 1, 3, 1);
        vrep(2, 0, 0, 1, 1, 2, 1);

        // async reset mid-ON with pending=2 and ovf set
        rst_n = 1'b0;
        #2;
        step_no++;
        check_all(1'b0, 1'b0, 2'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vrep(8, 0, 0, 0, 0, 0, 0);
        vec(1, 0, 1, 1, 0, 0);
        vrep(3, 0, 0, 1, 1, 0, 0);
        vrep(3, 0, 0, 0, 1, 0, 0);
        vec(0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
